backend_dispatch_credit_ctrl: RTL and testbench
===============================================

BACKEND_DISPATCH_CREDIT_CTRL -- requirements
Module: backend_dispatch_credit_ctrl

Interface
REQ-001 SHALL have parameter NUM_DISPATCH, default 2: number of parallel dispatch slots; slot 0 is oldest in program order.
REQ-002 SHALL have parameter LOG2_NUM_EU, default 2: execution-unit index width; NUM_EU = 2**LOG2_NUM_EU.
REQ-003 SHALL have parameter IQ_DEPTH, default 4: IQueue entries per execution unit; CW = clog2(IQ_DEPTH+1).
REQ-004 SHALL have port clk, input, 1: sole clock, all state on the rising edge.
REQ-005 SHALL have port reset, input, 1: reset, asynchronous, active-high.
REQ-006 SHALL have port req_valid_i, input, NUM_DISPATCH: per-slot dispatch request.
REQ-007 SHALL have port req_euidx_i, input, NUM_DISPATCH x LOG2_NUM_EU: target execution unit per slot.
REQ-008 SHALL have port grant_o, output, NUM_DISPATCH: per-slot dispatch accepted this cycle.
REQ-009 SHALL have port credit_return_i, input, NUM_EU: one IQueue entry freed in that execution unit.
REQ-010 SHALL have port flush_i, input, 1: pipeline flush request.
REQ-011 SHALL have port credits_o, output, NUM_EU x CW: current credit count per execution unit.
REQ-012 SHALL have port draining_o, output, 1: controller is in DRAIN.
REQ-013 SHALL have port credit_err_o, output, 1: sticky credit-overflow error.
REQ-014 SHALL have port stall_cnt_o, output, 32: dispatch stall cycle counter.

Function
REQ-015 SHALL keep one credit counter per execution unit, counting free IQueue entries.
REQ-016 SHALL compute grant_o combinationally from registered credits and the current request: grant[k] = req_valid_i[k] AND (k==0 OR grant[k-1]) AND credit available for euidx[k] after subtracting grants to the same EU from slots <k AND state==RUN.
REQ-017 SHALL grant in order: the first ungranted slot blocks every younger slot in the same cycle.
REQ-018 SHALL update each counter at the clock edge by +credit_return_i[e] minus the number of same-cycle grants to e; credits returned in cycle t are usable for grants from cycle t+1.
REQ-019 SHALL saturate a counter at IQ_DEPTH when a return arrives at IQ_DEPTH with no offsetting grant, and set credit_err_o, which stays set until reset.
REQ-020 SHALL implement FSM states RUN and DRAIN: RUN->DRAIN on flush_i; DRAIN->RUN at the first edge where every counter, including the same-edge update, equals IQ_DEPTH and flush_i is low.
REQ-021 SHALL force grant_o to all-zero in DRAIN and in the cycle flush_i is asserted.
REQ-022 SHALL keep flush_i asserted while in DRAIN holding the block in DRAIN.
REQ-023 SHALL drive draining_o high exactly when the state is DRAIN.
REQ-024 SHALL accept credit returns in all states.

Reset
REQ-025 SHALL, on reset high, asynchronously set every counter to IQ_DEPTH, state to RUN, credit_err_o to 0 and stall_cnt_o to 0.
REQ-026 SHALL drive grant_o to 0 while reset is high.
REQ-027 SHALL, when reset asserts mid-DRAIN or mid-dispatch, discard in-flight state, with no grant on the first post-reset edge except from fresh requests.

Configuration
REQ-028 SHALL, with macro DISPATCH_STALL_CNT_EN defined, increment stall_cnt_o each cycle req_valid_i[0]==1 and grant_o[0]==0, saturating at 0xFFFFFFFF.
REQ-029 SHALL, with DISPATCH_STALL_CNT_EN undefined, tie stall_cnt_o to 0 and instantiate no counter logic.

Verification
REQ-030 SHALL cover: after reset, request slot0 EU1 and slot1 EU1 for 2 cycles -> 4 grants, credits_o[EU1]=0, third-cycle requests not granted.
REQ-031 SHALL cover: credits EU2=0 and EU3=4, with slot0->EU2 and slot1->EU3 -> grant_o=00, in-order block of slot1.
REQ-032 SHALL cover: credits EU0=0, with credit_return_i[0]=1 and slot0->EU0 in the same cycle -> no grant that cycle, grant next cycle, credits EU0 back to 0.
REQ-033 SHALL cover: flush_i pulse with EU0 at 2 credits -> draining_o=1 and no grants until 2 returns, then RUN on that edge.
REQ-034 SHALL cover: return to EU3 at IQ_DEPTH=4 -> credits stay 4 and credit_err_o=1 until reset.
REQ-035 SHALL cover, with DISPATCH_STALL_CNT_EN: slot0 valid with 0 credits for 5 cycles -> stall_cnt_o=5; with the macro undefined -> stall_cnt_o=0.

Source files
------------

// File: rtl/backend_dispatch_credit_ctrl.sv
// ---------------------------------------------------------------------------------------------
// backend_dispatch_credit_ctrl
//
// Credit-based dispatch controller. Keeps one counter per execution unit (EU) holding the
// number of free IQueue entries, grants up to NUM_DISPATCH in-order dispatch requests per
// cycle against those credits, and drains all outstanding entries after a pipeline flush.
//
// Parameters:
//   NUM_DISPATCH : parallel dispatch slots, slot 0 is the oldest in program order
//   LOG2_NUM_EU  : EU index width, NUM_EU = 2**LOG2_NUM_EU
//   IQ_DEPTH     : IQueue entries per EU, counter width CW = clog2(IQ_DEPTH+1)
//
// Ports:
//   clk             : clock, all state on the rising edge
//   reset           : asynchronous active-high reset
//   req_valid_i     : per-slot dispatch request
//   req_euidx_i     : per-slot target EU, slot k at [k*LOG2_NUM_EU +: LOG2_NUM_EU]
//   grant_o         : per-slot dispatch accepted this cycle (combinational)
//   credit_return_i : one IQueue entry freed in the corresponding EU
//   flush_i         : pipeline flush, enters DRAIN and holds it while high
//   credits_o       : per-EU credit count, EU e at [e*CW +: CW]
//   draining_o      : high while in DRAIN
//   credit_err_o    : sticky credit-overflow error, cleared only by reset
//   stall_cnt_o     : cycles where slot 0 requested and was not granted
//
// Build option:
//   DISPATCH_STALL_CNT_EN : when defined, implements the saturating 32-bit stall counter;
//                           when undefined, stall_cnt_o is tied to zero.
// ---------------------------------------------------------------------------------------------
module backend_dispatch_credit_ctrl #(
    parameter int unsigned  NUM_DISPATCH = 2,
    parameter int unsigned  LOG2_NUM_EU  = 2,
    parameter int unsigned  IQ_DEPTH     = 4,
    localparam int unsigned NUM_EU       = 2 ** LOG2_NUM_EU,
    localparam int unsigned CW           = $clog2(IQ_DEPTH + 1)
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_DISPATCH-1:0]             req_valid_i,
    input  logic [NUM_DISPATCH*LOG2_NUM_EU-1:0] req_euidx_i,
    output logic [NUM_DISPATCH-1:0]             grant_o,
    input  logic [NUM_EU-1:0]                   credit_return_i,
    input  logic                                flush_i,
    output logic [NUM_EU*CW-1:0]                credits_o,
    output logic                                draining_o,
    output logic                                credit_err_o,
    output logic [31:0]                         stall_cnt_o
);

    localparam logic [CW-1:0] DepthC = CW'(IQ_DEPTH);
    localparam logic [CW:0]   DepthX = {1'b0, DepthC};
    localparam logic [CW-1:0] CntOne = CW'(1);

    typedef enum logic [0:0] {
        StRun,
        StDrain
    } state_e;

    state_e                         state_q, state_d;
    logic [NUM_EU-1:0][CW-1:0]      credits_q, credits_d;
    logic                           err_q, err_d;

    // Per-EU count of grants issued this cycle. A grant is only issued while credits exceed
    // this count, so it never exceeds IQ_DEPTH and fits in CW bits.
    logic [NUM_EU-1:0][CW-1:0]      used;
    logic [NUM_DISPATCH-1:0]        grant;
    logic [LOG2_NUM_EU-1:0]         eu;
    logic                           blocked;

    logic [CW:0]                    sum;
    logic                           overflow;
    logic                           all_full;

    // -----------------------------------------------------------------------------------------
    // In-order grant: walk the slots oldest first; the first slot that cannot be granted
    // blocks every younger slot. Credits consumed by older slots are charged before younger
    // slots targeting the same EU are considered.
    // -----------------------------------------------------------------------------------------
    always_comb begin
        grant   = '0;
        used    = '0;
        eu      = '0;
        blocked = 1'b0;
        if ((state_q == StRun) && !flush_i && !reset) begin
            for (int unsigned k = 0; k < NUM_DISPATCH; k++) begin
                eu = req_euidx_i[k*LOG2_NUM_EU +: LOG2_NUM_EU];
                if (!blocked && req_valid_i[k] && (credits_q[eu] > used[eu])) begin
                    grant[k] = 1'b1;
                    used[eu] = used[eu] + CntOne;
                end else begin
                    blocked = 1'b1;
                end
            end
        end
    end

    // -----------------------------------------------------------------------------------------
    // Credit update: +return -grants. A return that would push a counter past IQ_DEPTH is an
    // accounting error; the counter clamps and the sticky error flag is raised.
    // -----------------------------------------------------------------------------------------
    always_comb begin
        credits_d = credits_q;
        sum       = '0;
        overflow  = 1'b0;
        all_full  = 1'b1;
        for (int unsigned e = 0; e < NUM_EU; e++) begin
            sum = {1'b0, credits_q[e]} + {{CW{1'b0}}, credit_return_i[e]} - {1'b0, used[e]};
            if (sum > DepthX) begin
                credits_d[e] = DepthC;
                overflow     = 1'b1;
            end else begin
                credits_d[e] = sum[CW-1:0];
            end
            if (credits_d[e] != DepthC) begin
                all_full = 1'b0;
            end
        end
        err_d = err_q | overflow;
    end

    // -----------------------------------------------------------------------------------------
    // RUN/DRAIN control. DRAIN exits on the edge where every counter, including this edge's
    // update, is back at IQ_DEPTH and flush is no longer asserted.
    // -----------------------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun: begin
                if (flush_i) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (!flush_i && all_full) begin
                    state_d = StRun;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StRun;
            credits_q <= {NUM_EU{DepthC}};
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            credits_q <= credits_d;
            err_q     <= err_d;
        end
    end

    assign grant_o      = grant;
    assign credits_o    = credits_q;
    assign draining_o   = (state_q == StDrain);
    assign credit_err_o = err_q;

    // -----------------------------------------------------------------------------------------
    // Optional slot-0 stall counter, saturating at all-ones.
    // -----------------------------------------------------------------------------------------
`ifdef DISPATCH_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (req_valid_i[0] && !grant[0] && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`else
    assign stall_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_backend_dispatch_credit_ctrl.sv
// ---------------------------------------------------------------------------------------------
// Bench for backend_dispatch_credit_ctrl (default parameters: 2 slots, 4 EUs, depth 4).
// A behavioural model tracks free entries per EU as plain integers and is compared against
// the DUT on every falling edge; directed scenarios add hand-computed literal checks.
// ---------------------------------------------------------------------------------------------
module tb_backend_dispatch_credit_ctrl;

    localparam int ND = 2;
    localparam int NE = 4;
    localparam int D  = 4;
    localparam int CW = 3;

`ifdef DISPATCH_STALL_CNT_EN
    localparam logic [31:0] StallExp = 32'd5;
`else
    localparam logic [31:0] StallExp = 32'd0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [ND-1:0]     req_valid = '0;
    logic [ND*2-1:0]   req_euidx = '0;
    logic [ND-1:0]     grant;
    logic [NE-1:0]     ret = '0;
    logic              flush = 1'b0;
    logic [NE*CW-1:0]  credits;
    logic              draining;
    logic              err;
    logic [31:0]       stall;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Model state
    int          m_cred[NE] = '{D, D, D, D};
    bit          m_drain = 1'b0;
    bit          m_err = 1'b0;
    logic [31:0] m_stall = '0;

    logic [ND-1:0] mg;
    logic [ND-1:0] cg;
    int            mn;
    bit            mfull;

    backend_dispatch_credit_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid_i     (req_valid),
        .req_euidx_i     (req_euidx),
        .grant_o         (grant),
        .credit_return_i (ret),
        .flush_i         (flush),
        .credits_o       (credits),
        .draining_o      (draining),
        .credit_err_o    (err),
        .stall_cnt_o     (stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] cred(input int e);
        return credits[e*CW +: CW];
    endfunction

    // Oldest-first dispatch: take each slot while it requests and its EU still has a free
    // entry after older slots of this cycle took theirs; stop at the first that cannot go.
    function automatic logic [ND-1:0] exp_grant();
        int            taken[NE];
        logic [ND-1:0] g;
        g = '0;
        foreach (taken[i]) taken[i] = 0;
        if (reset || m_drain || flush) return g;
        for (int k = 0; k < ND; k++) begin
            int e;
            if (!req_valid[k]) break;
            e = int'(req_euidx[2*k +: 2]);
            if (m_cred[e] - taken[e] <= 0) break;
            g[k] = 1'b1;
            taken[e]++;
        end
        return g;
    endfunction

    // Model update at the clock edge, reset asynchronously.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            foreach (m_cred[i]) m_cred[i] = D;
            m_drain = 1'b0;
            m_err   = 1'b0;
            m_stall = '0;
        end else begin
            mg    = exp_grant();
            mfull = 1'b1;
            for (int e = 0; e < NE; e++) begin
                mn = m_cred[e] + int'(ret[e]);
                for (int k = 0; k < ND; k++)
                    if (mg[k] && int'(req_euidx[2*k +: 2]) == e) mn = mn - 1;
                if (mn > D) begin
                    mn    = D;
                    m_err = 1'b1;
                end
                m_cred[e] = mn;
                if (mn != D) mfull = 1'b0;
            end
            if (!m_drain && flush) m_drain = 1'b1;
            else if (m_drain && !flush && mfull) m_drain = 1'b0;
`ifdef DISPATCH_STALL_CNT_EN
            if (req_valid[0] && !mg[0] && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
`endif
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            cg = exp_grant();
            check("cmp_grant", 64'(grant), 64'(cg));
            for (int e = 0; e < NE; e++)
                check($sformatf("cmp_credits[%0d]", e), 64'(cred(e)), 64'(m_cred[e]));
            check("cmp_draining", 64'(draining), 64'(m_drain));
            check("cmp_err", 64'(err), 64'(m_err));
            check("cmp_stall", 64'(stall), 64'(m_stall));
        end
    end

    task automatic drive(input logic [ND-1:0] v, input int e0, input int e1,
                         input logic [NE-1:0] r, input logic f);
        logic [1:0] a;
        logic [1:0] b;
        a = e0[1:0];
        b = e1[1:0];
        req_valid = v;
        req_euidx = {b, a};
        ret       = r;
        flush     = f;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with requests pending: no grants, all counters full.
        #2;
        reset  = 1'b1;
        chk_en = 1'b1;
        drive(2'b11, 1, 1, 4'b0000, 1'b0);
        @(negedge clk);
        check("rst_grant", 64'(grant), 64'd0);
        check("rst_credits", 64'(credits), 64'h924);
        check("rst_draining", 64'(draining), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_stall", 64'(stall), 64'd0);
        tick();
        reset = 1'b0;

        // Two slots to EU1 for two cycles: four grants, then EU1 is empty.
        @(negedge clk);
        check("s1_c1_grant", 64'(grant), 64'b11);
        tick();
        @(negedge clk);
        check("s1_c2_grant", 64'(grant), 64'b11);
        tick();
        @(negedge clk);
        check("s1_c3_grant", 64'(grant), 64'b00);
        check("s1_eu1_credits", 64'(cred(1)), 64'd0);
        check("s1_model_eu1", 64'(m_cred[1]), 64'd0);
        drive(2'b00, 0, 0, 4'b0010, 1'b0);
        repeat (4) tick();
        @(negedge clk);
        check("s1_eu1_refill", 64'(cred(1)), 64'd4);

        // EU2 empty, EU3 full: slot0->EU2 blocks slot1->EU3.
        drive(2'b11, 2, 2, 4'b0000, 1'b0);
        tick();
        tick();
        drive(2'b11, 2, 3, 4'b0000, 1'b0);
        @(negedge clk);
        check("s2_grant_blocked", 64'(grant), 64'b00);
        check("s2_eu2_credits", 64'(cred(2)), 64'd0);
        check("s2_eu3_credits", 64'(cred(3)), 64'd4);
        tick();
        drive(2'b00, 0, 0, 4'b0100, 1'b0);
        repeat (4) tick();

        // Same-cycle return is not usable until the next cycle.
        drive(2'b11, 0, 0, 4'b0000, 1'b0);
        tick();
        tick();
        drive(2'b01, 0, 0, 4'b0001, 1'b0);
        @(negedge clk);
        check("s3_ret_same_cycle", 64'(grant), 64'b00);
        tick();
        drive(2'b01, 0, 0, 4'b0000, 1'b0);
        @(negedge clk);
        check("s3_ret_next_cycle", 64'(grant), 64'b01);
        check("s3_eu0_one", 64'(cred(0)), 64'd1);
        tick();
        drive(2'b00, 0, 0, 4'b0000, 1'b0);
        @(negedge clk);
        check("s3_eu0_zero", 64'(cred(0)), 64'd0);
        drive(2'b00, 0, 0, 4'b0001, 1'b0);
        repeat (4) tick();

        // Flush with EU0 at 2: drain until two returns, RUN on the second return's edge.
        drive(2'b11, 0, 0, 4'b0000, 1'b0);
        tick();
        drive(2'b11, 1, 1, 4'b0000, 1'b1);
        @(negedge clk);
        check("s4_flush_grant", 64'(grant), 64'b00);
        check("s4_eu0_two", 64'(cred(0)), 64'd2);
        tick();
        drive(2'b11, 1, 1, 4'b0001, 1'b0);
        @(negedge clk);
        check("s4_drain_a", 64'(draining), 64'd1);
        check("s4_drain_a_grant", 64'(grant), 64'b00);
        check("s4_model_drain", 64'(m_drain), 64'd1);
        tick();
        @(negedge clk);
        check("s4_drain_b", 64'(draining), 64'd1);
        check("s4_drain_b_grant", 64'(grant), 64'b00);
        tick();
        drive(2'b11, 1, 1, 4'b0000, 1'b0);
        @(negedge clk);
        check("s4_run_again", 64'(draining), 64'd0);
        check("s4_run_grant", 64'(grant), 64'b11);
        check("s4_eu0_full", 64'(cred(0)), 64'd4);
        tick();
        drive(2'b00, 0, 0, 4'b0010, 1'b0);
        repeat (2) tick();

        // Flush held high keeps DRAIN even with all counters full.
        drive(2'b00, 0, 0, 4'b0000, 1'b1);
        tick();
        @(negedge clk);
        check("s4_hold_a", 64'(draining), 64'd1);
        tick();
        @(negedge clk);
        check("s4_hold_b", 64'(draining), 64'd1);
        drive(2'b00, 0, 0, 4'b0000, 1'b0);
        tick();
        @(negedge clk);
        check("s4_hold_exit", 64'(draining), 64'd0);

        // Return at full: counter stays at depth, sticky error.
        drive(2'b00, 0, 0, 4'b1000, 1'b0);
        tick();
        drive(2'b00, 0, 0, 4'b0000, 1'b0);
        @(negedge clk);
        check("s5_eu3_sat", 64'(cred(3)), 64'd4);
        check("s5_err_set", 64'(err), 64'd1);
        repeat (3) tick();
        @(negedge clk);
        check("s5_err_sticky", 64'(err), 64'd1);

        // Reset mid-DRAIN with requests: state discarded, fresh requests granted after.
        drive(2'b11, 2, 2, 4'b0000, 1'b1);
        tick();
        drive(2'b11, 2, 2, 4'b0000, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check("s6_rst_draining", 64'(draining), 64'd0);
        check("s6_rst_err", 64'(err), 64'd0);
        check("s6_rst_grant", 64'(grant), 64'b00);
        check("s6_rst_credits", 64'(credits), 64'h924);
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("s6_post_rst_grant", 64'(grant), 64'b11);
        tick();
        tick();

        // Slot 0 to empty EU2 for five cycles.
        drive(2'b01, 2, 0, 4'b0000, 1'b0);
        repeat (5) tick();
        drive(2'b00, 0, 0, 4'b0000, 1'b0);
        @(negedge clk);
        check("s7_stall_cnt", 64'(stall), 64'(StallExp));
        check("s7_model_stall", 64'(m_stall), 64'(StallExp));
        repeat (2) tick();

        @(negedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
